// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
//   Shared definitions for the counter sequencer: FSM state encoding, command
//   opcodes and a small helper that classifies states.
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

    // Sequencer states. DONE is a single-cycle completion state for one-shot runs.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Command opcodes carried on cmd_op.
    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_PAUSE  = 2'b10;
    localparam logic [1:0] OP_RESUME = 2'b11;

    // A run is in progress (stepping or frozen) in RUN and PAUSE.
    function automatic logic is_busy_state(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
//   Divides enabled cycles into step pulses: step is high on every (div+1)-th
//   enabled cycle. A disabled cycle freezes the phase, so a paused run resumes
//   exactly where it left off.
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   enable  in   count this cycle
//   clear   in   force phase back to 0 (start of a new run)
//   div     in   divider value; step when phase == div
//   step    out  combinational step strobe (enable && phase == div)
// -----------------------------------------------------------------------------
module counter_prescaler
    import counter_ctrl_pkg::*;
#(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  step
);

    localparam logic [PRESCALE_W-1:0] PH_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] phase_r;
    logic [PRESCALE_W-1:0] phase_next_s;

    assign step = enable && (phase_r == div);

    // Next phase: clear wins, otherwise advance and wrap on step, hold when disabled.
    always_comb begin
        phase_next_s = phase_r;
        if (clear) begin
            phase_next_s = '0;
        end else if (enable) begin
            if (step) begin
                phase_next_s = '0;
            end else begin
                phase_next_s = phase_r + PH_ONE;
            end
        end else begin
            phase_next_s = phase_r;
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_r <= '0;
        end else begin
            phase_r <= phase_next_s;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//   Command-driven sequencer for a small up-counter. Accepts START / STOP /
//   PAUSE / RESUME commands, latches the run configuration on START, steps the
//   count through a prescaler and reports tick / done / err events.
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   cmd_valid     in   command present
//   cmd_ready     out  command can be accepted (low only in DONE and in reset)
//   cmd_op        in   00 START, 01 STOP, 10 PAUSE, 11 RESUME
//   cfg_limit     in   terminal count, sampled on accepted START
//   cfg_reload    in   1 auto-reload, 0 one-shot, sampled on accepted START
//   cfg_prescale  in   step every cfg_prescale+1 running cycles, sampled on START
//   count         out  current count
//   busy          out  RUN or PAUSE
//   paused        out  PAUSE
//   tick          out  1-cycle pulse coinciding with the terminal-step count update
//   done          out  1-cycle pulse during the DONE cycle of a one-shot run
//   err           out  1-cycle pulse after an illegal accepted command
// All outputs are registered; effects of a command appear the cycle after it
// is accepted.
// -----------------------------------------------------------------------------
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cfg_limit,
    input  logic                  cfg_reload,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  paused,
    output logic                  tick,
    output logic                  done,
    output logic                  err
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t                state_r;
    state_t                state_next_s;

    logic [WIDTH-1:0]      limit_r;
    logic                  reload_r;
    logic [PRESCALE_W-1:0] prescale_r;

    logic [WIDTH-1:0]      count_r;
    logic [WIDTH-1:0]      count_next_s;

    logic                  cmd_ready_r;
    logic                  busy_r;
    logic                  paused_r;
    logic                  tick_r;
    logic                  done_r;
    logic                  err_r;
    logic                  tick_next_s;
    logic                  err_next_s;

    logic                  accept_s;
    logic                  start_s;
    logic                  halt_s;
    logic                  pre_en_s;
    logic                  step_s;

    assign accept_s = cmd_valid && cmd_ready_r;

    // A new run begins only on an accepted START from IDLE.
    assign start_s = accept_s && (state_r == ST_IDLE) && (cmd_op == OP_START);

    // STOP or PAUSE accepted in RUN pre-empts any step in the same cycle, so the
    // prescaler must not advance either.
    assign halt_s   = accept_s && ((cmd_op == OP_STOP) || (cmd_op == OP_PAUSE));
    assign pre_en_s = (state_r == ST_RUN) && !halt_s;

    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (pre_en_s),
        .clear  (start_s),
        .div    (prescale_r),
        .step   (step_s)
    );

    // Next-state, next-count and event decode.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        tick_next_s  = 1'b0;
        err_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (cmd_op == OP_START) begin
                        state_next_s = ST_RUN;
                        count_next_s = '0;
                    end else begin
                        err_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && (cmd_op == OP_STOP)) begin
                    state_next_s = ST_IDLE;
                    count_next_s = '0;
                end else if (accept_s && (cmd_op == OP_PAUSE)) begin
                    state_next_s = ST_PAUSE;
                end else begin
                    // START / RESUME here are illegal but do not disturb stepping.
                    err_next_s = accept_s;
                    if (step_s) begin
                        if (count_r == limit_r) begin
                            tick_next_s = 1'b1;
                            if (reload_r) begin
                                count_next_s = '0;
                            end else begin
                                // One-shot: hold at the limit and finish.
                                state_next_s = ST_DONE;
                            end
                        end else begin
                            count_next_s = count_r + CNT_ONE;
                        end
                    end else begin
                        count_next_s = count_r;
                    end
                end
            end
            ST_PAUSE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_RESUME: state_next_s = ST_RUN;
                        OP_STOP: begin
                            state_next_s = ST_IDLE;
                            count_next_s = '0;
                        end
                        default:   err_next_s = 1'b1;
                    endcase
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                count_next_s = '0;
            end
        endcase
    end

    // State, count and registered status / event outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            count_r     <= '0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            paused_r    <= 1'b0;
            tick_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            count_r     <= count_next_s;
            cmd_ready_r <= (state_next_s != ST_DONE);
            busy_r      <= is_busy_state(state_next_s);
            paused_r    <= (state_next_s == ST_PAUSE);
            tick_r      <= tick_next_s;
            done_r      <= (state_next_s == ST_DONE);
            err_r       <= err_next_s;
        end
    end

    // Run configuration, captured only on the START that begins a run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            limit_r    <= '0;
            reload_r   <= 1'b0;
            prescale_r <= '0;
        end else if (start_s) begin
            limit_r    <= cfg_limit;
            reload_r   <= cfg_reload;
            prescale_r <= cfg_prescale;
        end else begin
            limit_r    <= limit_r;
            reload_r   <= reload_r;
            prescale_r <= prescale_r;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign count     = count_r;
    assign busy      = busy_r;
    assign paused    = paused_r;
    assign tick      = tick_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl
//   Self-checking bench for counter_ctrl. Each driven cycle runs a reference
//   model (run progress kept as a count of advancing cycles) and queues the
//   expected outputs for the following cycle; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cfg_limit = 4'd0;
    logic       cfg_reload = 1'b0;
    logic [3:0] cfg_prescale = 4'd0;
    logic       cmd_ready, busy, paused, tick, done, err;
    logic [3:0] count;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cfg_limit    (cfg_limit),
        .cfg_reload   (cfg_reload),
        .cfg_prescale (cfg_prescale),
        .count        (count),
        .busy         (busy),
        .paused       (paused),
        .tick         (tick),
        .done         (done),
        .err          (err)
    );

    typedef struct {
        int         due;
        logic [9:0] exp;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;

    // Reference model: a run is described by how many cycles it has advanced.
    bit m_active, m_pause, m_done, m_rdy, m_rl;
    int m_runs, m_lim, m_pre, m_idle_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] outs_now();
        return {cmd_ready, busy, paused, tick, done, err, count};
    endfunction

    task automatic model_reset();
        m_active = 0; m_pause = 0; m_done = 0; m_rdy = 0; m_rl = 0;
        m_runs = 0; m_lim = 0; m_pre = 0; m_idle_cnt = 0;
    endtask

    // Drive one cycle's inputs, advance the model, queue the expected outputs.
    task automatic apply(input bit v, input logic [1:0] op, input int lim,
                         input bit rl, input int ps);
        bit acc, t, d, e;
        int per, cnt;
        cmd_valid    = v;
        cmd_op       = op;
        cfg_limit    = 4'(lim);
        cfg_reload   = rl;
        cfg_prescale = 4'(ps);
        acc = v && m_rdy && !m_done;
        t = 0; e = 0;
        if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (acc && op == OP_START) begin
                m_active = 1; m_pause = 0; m_runs = 0;
                m_lim = lim; m_pre = ps; m_rl = rl;
            end else e = acc;
        end else if (!m_pause) begin
            if (acc && op == OP_STOP) begin
                m_active = 0; m_idle_cnt = 0;
            end else if (acc && op == OP_PAUSE) begin
                m_pause = 1;
            end else begin
                e = acc;
                m_runs++;
                per = (m_lim + 1) * (m_pre + 1);
                if (m_runs == per) begin
                    t = 1;
                    if (m_rl) m_runs = 0;
                    else begin
                        m_active = 0; m_done = 1; m_idle_cnt = m_lim;
                    end
                end
            end
        end else begin
            if (acc && op == OP_RESUME) m_pause = 0;
            else if (acc && op == OP_STOP) begin
                m_active = 0; m_idle_cnt = 0;
            end else e = acc;
        end
        m_rdy = 1;
        cnt = m_active ? (m_runs / (m_pre + 1)) % (m_lim + 1) : m_idle_cnt;
        d = m_done;
        q.push_back('{due: cyc + 1,
                      exp: {!m_done, m_active, m_active && m_pause, t, d, e, 4'(cnt)}});
    endtask

    task automatic cyc_drive(input bit v, input logic [1:0] op, input int lim,
                             input bit rl, input int ps);
        @(posedge clk); #1;
        apply(v, op, lim, rl, ps);
    endtask

    // Idle cycles with random (ignored) configuration on the bus.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc_drive(1'b0, 2'($urandom_range(0, 3)), $urandom_range(0, 15),
                      1'($urandom_range(0, 1)), $urandom_range(0, 15));
    endtask

    task automatic check_reset_outs(input string name);
        n_tests++;
        if (outs_now() !== 10'd0) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, outs_now(), 10'd0);
        end
    endtask

    // Release reset just before a drive slot so the model tracks cmd_ready.
    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        apply(1'b0, OP_START, 0, 1'b0, 0);
    endtask

    // Monitor: compare outputs against the expectation due this cycle.
    always @(negedge clk) begin : monitor
        item_t it;
        if (reset) begin
            while (q.size() > 0 && q[0].due <= cyc) begin
                it = q.pop_front();
                n_tests++;
                if (outs_now() !== it.exp) begin
                    n_fail++;
                    $display("FAIL cycle %0d {rdy,busy,paused,tick,done,err,count}: got %b required %b",
                             cyc, outs_now(), it.exp);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outs("reset_state");
        release_reset();
        idle(2);

        // One-shot, limit 3, no prescale.
        cyc_drive(1'b1, OP_START, 3, 1'b0, 0);
        idle(8);
        // Auto-reload, limit 15.
        cyc_drive(1'b1, OP_START, 15, 1'b1, 0);
        idle(40);
        cyc_drive(1'b1, OP_STOP, 0, 1'b0, 0);
        // Auto-reload, limit 1, prescale 2.
        cyc_drive(1'b1, OP_START, 1, 1'b1, 2);
        idle(20);
        cyc_drive(1'b1, OP_STOP, 0, 1'b0, 0);
        // Pause mid-prescale at count 2, hold 5 cycles, resume.
        cyc_drive(1'b1, OP_START, 5, 1'b0, 3);
        idle(9);
        cyc_drive(1'b1, OP_PAUSE, 0, 1'b0, 0);
        idle(5);
        cyc_drive(1'b1, OP_RESUME, 0, 1'b0, 0);
        idle(30);
        // Illegal commands: START in RUN, RESUME / PAUSE in IDLE.
        cyc_drive(1'b1, OP_START, 7, 1'b1, 1);
        idle(3);
        cyc_drive(1'b1, OP_START, 2, 1'b0, 0);
        idle(20);
        cyc_drive(1'b1, OP_STOP, 0, 1'b0, 0);
        cyc_drive(1'b1, OP_RESUME, 0, 1'b0, 0);
        cyc_drive(1'b1, OP_PAUSE, 0, 1'b0, 0);
        idle(2);
        // STOP on the terminal-step cycle.
        cyc_drive(1'b1, OP_START, 2, 1'b0, 0);
        idle(2);
        cyc_drive(1'b1, OP_STOP, 0, 1'b0, 0);
        idle(3);
        // Asynchronous reset in the middle of a run.
        cyc_drive(1'b1, OP_START, 9, 1'b1, 1);
        idle(5);
        @(posedge clk); #3;
        reset = 1'b0;
        #1 check_reset_outs("async_reset_mid_run");
        q.delete();
        model_reset();
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            int ps;
            ps = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            cyc_drive(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                      $urandom_range(0, 15), 1'($urandom_range(0, 1)), ps);
        end
        idle(3);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
